// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for the round-robin arbitrating mux: FSM encodings,
// default parameter values and a small pointer helper.
package rr_mux_arb_pkg;

  // Packet-lock state encodings
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Default parameter values
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 8;
  localparam int DEF_SEL_W  = 4;
  localparam int DEF_RR_EN  = 1;

  // Index of the channel after g, wrapping at n
  function automatic int wrap_inc(input int g, input int n);
    return (g >= n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: returns the first set request
// at or above ptr, wrapping to the lowest set request below ptr.
// A zero ptr gives plain fixed priority (index 0 highest).
module rr_pick #(
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 4
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  idx,
  output logic [NUM_IN-1:0] onehot,
  output logic              any
);

  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;
  logic             hi_any;
  logic             lo_any;

  // Descending scan so the lowest qualifying index is the one left standing
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = SEL_W'(i);
        lo_any = 1'b1;
        if (SEL_W'(i) >= ptr) begin
          hi_idx = SEL_W'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  assign idx    = hi_any ? hi_idx : lo_idx;
  assign any    = lo_any;
  assign onehot = lo_any ? (NUM_IN'(1) << idx) : '0;

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel arbitrating mux with packet-level grant locking and a
// registered output stage. One beat per cycle at full throughput.
//
// Handshake: a beat moves on channel i when in_vld[i] & in_rdy[i] are both
// high at a rising clk edge, and leaves on out_vld & out_rdy. Producers hold
// in_vld/in_last/in_data stable until accepted and must not derive in_vld
// from in_rdy (in_rdy is a combinational function of in_vld).
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int RR_EN  = DEF_RR_EN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_vld,
  input  logic [NUM_IN-1:0]       in_last,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_rdy,
  output logic                    out_vld,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_rdy,
  output logic [0:0]              dbg_state,
  output logic [SEL_W-1:0]        dbg_ptr
);

  logic [0:0]        state;
  logic [SEL_W-1:0]  lock_ch;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  pick_ptr;
  logic [SEL_W-1:0]  g;
  logic [NUM_IN-1:0] g_oh;
  logic              any_vld;
  logic              load;
  logic              xfer;
  logic              g_last;
  logic [WIDTH-1:0]  g_data;
  logic [SEL_W-1:0]  ptr_nxt;

  // Fixed priority is rotating priority with the start pinned at channel 0
  assign pick_ptr = (RR_EN != 0) ? ptr : '0;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req    (in_vld),
    .ptr    (pick_ptr),
    .idx    (g),
    .onehot (g_oh),
    .any    (any_vld)
  );

  // Output register can take a beat when empty or draining this cycle
  assign load = ~out_vld | out_rdy;

  // While locked only the owning channel may move; a stalled owner blocks all.
  // rst gates the grant so nothing is accepted while reset is held.
  assign xfer   = ~rst & load & any_vld & ((state == ST_IDLE) | (g == lock_ch));
  assign in_rdy = xfer ? g_oh : '0;
  assign g_last = |(in_last & g_oh);

  // Select the granted channel's data word
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (g_oh[i]) g_data = g_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  assign ptr_nxt = SEL_W'(wrap_inc(int'(g), NUM_IN));

  // Registered output stage; data/sel/last hold when nothing loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_sel  <= '0;
    end else if (load) begin
      if (xfer) begin
        out_vld  <= 1'b1;
        out_data <= g_data;
        out_last <= g_last;
        out_sel  <= g;
      end else begin
        out_vld  <= 1'b0;
      end
    end
  end

  // Packet lock FSM and fairness pointer; pointer only moves on packet end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      if (g_last) begin
        state <= ST_IDLE;
        ptr   <= ptr_nxt;
      end else begin
        state   <= ST_LOCKED;
        lock_ch <= g;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: one round-robin instance and one
// fixed-priority instance share the same stimulus.
module tb_rr_mux_arb;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 8;
  localparam int SEL_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN-1:0]       in_vld;
  logic [NUM_IN-1:0]       in_last;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_rdy;

  logic [NUM_IN-1:0] rr_in_rdy, fp_in_rdy;
  logic              rr_out_vld, fp_out_vld;
  logic              rr_out_last, fp_out_last;
  logic [WIDTH-1:0]  rr_out_data, fp_out_data;
  logic [SEL_W-1:0]  rr_out_sel, fp_out_sel;
  logic [0:0]        rr_dbg_state, fp_dbg_state;
  logic [SEL_W-1:0]  rr_dbg_ptr, fp_dbg_ptr;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_w;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rr_mux_arb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_last(in_last), .in_data(in_data),
    .in_rdy(rr_in_rdy), .out_vld(rr_out_vld), .out_data(rr_out_data),
    .out_last(rr_out_last), .out_sel(rr_out_sel), .out_rdy(out_rdy),
    .dbg_state(rr_dbg_state), .dbg_ptr(rr_dbg_ptr)
  );

  rr_mux_arb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .RR_EN(0)) u_fp (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_last(in_last), .in_data(in_data),
    .in_rdy(fp_in_rdy), .out_vld(fp_out_vld), .out_data(fp_out_data),
    .out_last(fp_out_last), .out_sel(fp_out_sel), .out_rdy(out_rdy),
    .dbg_state(fp_dbg_state), .dbg_ptr(fp_dbg_ptr)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NUM_IN-1:0] vld, input logic [NUM_IN-1:0] last);
    in_vld  = vld;
    in_last = last;
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
    in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    in_vld  = '0;
    in_last = '0;
    in_data = '0;
    out_rdy = 1'b0;
    #2;
    // Reset state
    chk("rst_out_vld",  rr_out_vld, 0);
    chk("rst_out_data", rr_out_data, 0);
    chk("rst_out_sel",  rr_out_sel, 0);
    chk("rst_out_last", rr_out_last, 0);
    chk("rst_in_rdy",   rr_in_rdy, 0);
    chk("rst_state",    rr_dbg_state, 0);
    chk("rst_ptr",      rr_dbg_ptr, 0);
    chk("rst_fp_vld",   fp_out_vld, 0);
    step();
    step();
    rst = 1'b0;

    // ---- Round-robin fairness: all valid, single-beat packets ----
    for (int i = 0; i < NUM_IN; i++) set_ch(i, 32'hC0DE_0000 | i);
    exp_q.push_back(32'hC0DE_0000); exp_q.push_back(32'hC0DE_0001);
    exp_q.push_back(32'hC0DE_0002); exp_q.push_back(32'hC0DE_0003);
    exp_q.push_back(32'hC0DE_0004); exp_q.push_back(32'hC0DE_0005);
    exp_q.push_back(32'hC0DE_0006); exp_q.push_back(32'hC0DE_0007);
    exp_q.push_back(32'hC0DE_0000);
    out_rdy = 1'b1;
    drive(8'hFF, 8'hFF);
    chk("rr_first_rdy", rr_in_rdy, 8'h01);
    chk("fp_first_rdy", fp_in_rdy, 8'h01);
    for (int k = 0; k < 9; k++) begin
      step();
      exp_w = exp_q.pop_front();
      chk("rr_seq_vld",  rr_out_vld, 1);
      chk("rr_seq_data", rr_out_data, exp_w);
      chk("rr_seq_sel",  rr_out_sel, exp_w[SEL_W-1:0]);
      chk("fp_seq_sel",  fp_out_sel, 0);
    end
    chk("rr_q_empty", exp_q.size(), 0);
    drive(8'h00, 8'h00);
    step();
    chk("rr_idle_vld", rr_out_vld, 0);
    chk("rr_idle_sel_hold", rr_out_sel, 0);
    chk("rr_ptr_after_rot", rr_dbg_ptr, 1);

    // ---- Packet lock: ch2 three beats, ch5 valid throughout (ptr=1) ----
    set_ch(2, 32'h2222_0001);
    drive(8'h24, 8'h20);
    chk("lk_b1_rdy", rr_in_rdy, 8'h04);
    step();
    chk("lk_b1_sel",   rr_out_sel, 2);
    chk("lk_b1_data",  rr_out_data, 32'h2222_0001);
    chk("lk_b1_last",  rr_out_last, 0);
    chk("lk_b1_state", rr_dbg_state, 1);
    drive(8'h20, 8'h20);               // owner stalls, ch5 still waiting
    chk("lk_stall_rdy", rr_in_rdy, 8'h00);
    step();
    chk("lk_stall_vld",   rr_out_vld, 0);
    chk("lk_stall_state", rr_dbg_state, 1);
    set_ch(2, 32'h2222_0002);
    drive(8'h24, 8'h20);
    chk("lk_b2_rdy", rr_in_rdy, 8'h04);
    step();
    chk("lk_b2_sel",  rr_out_sel, 2);
    chk("lk_b2_data", rr_out_data, 32'h2222_0002);
    set_ch(2, 32'h2222_0003);
    drive(8'h24, 8'h24);
    chk("lk_b3_rdy", rr_in_rdy, 8'h04);
    step();
    chk("lk_b3_sel",   rr_out_sel, 2);
    chk("lk_b3_data",  rr_out_data, 32'h2222_0003);
    chk("lk_b3_last",  rr_out_last, 1);
    chk("lk_b3_state", rr_dbg_state, 0);
    chk("lk_b3_ptr",   rr_dbg_ptr, 3);
    drive(8'h20, 8'h20);
    chk("lk_ch5_rdy", rr_in_rdy, 8'h20);
    step();
    chk("lk_ch5_sel",  rr_out_sel, 5);
    chk("lk_ch5_data", rr_out_data, 32'hC0DE_0005);
    chk("lk_ch5_ptr",  rr_dbg_ptr, 6);
    drive(8'h00, 8'h00);
    step();

    // ---- Backpressure: ch1 valid, out_rdy low for 4 cycles ----
    out_rdy = 1'b0;
    set_ch(1, 32'hB100_0001);
    drive(8'h02, 8'h02);
    chk("bp_load_rdy", rr_in_rdy, 8'h02);
    step();
    chk("bp_load_vld",  rr_out_vld, 1);
    chk("bp_load_data", rr_out_data, 32'hB100_0001);
    set_ch(1, 32'hB100_0002);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_rdy",  rr_in_rdy, 8'h00);
      step();
      chk("bp_hold_vld",  rr_out_vld, 1);
      chk("bp_hold_data", rr_out_data, 32'hB100_0001);
      chk("bp_hold_sel",  rr_out_sel, 1);
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_drain_rdy", rr_in_rdy, 8'h02);
    step();
    chk("bp_next_vld",  rr_out_vld, 1);
    chk("bp_next_data", rr_out_data, 32'hB100_0002);
    drive(8'h00, 8'h00);
    step();
    chk("bp_empty_vld", rr_out_vld, 0);
    chk("bp_ptr", rr_dbg_ptr, 2);

    // ---- Reset mid-packet: ch3 locked, output stalled ----
    out_rdy = 1'b0;
    drive(8'h08, 8'h00);
    chk("rm_rdy", rr_in_rdy, 8'h08);
    step();
    chk("rm_vld",    rr_out_vld, 1);
    chk("rm_sel",    rr_out_sel, 3);
    chk("rm_locked", rr_dbg_state, 1);
    rst = 1'b1;
    #1;
    chk("rm_async_vld",   rr_out_vld, 0);
    chk("rm_async_rdy",   rr_in_rdy, 8'h00);
    chk("rm_async_state", rr_dbg_state, 0);
    chk("rm_async_ptr",   rr_dbg_ptr, 0);
    step();
    rst     = 1'b0;
    out_rdy = 1'b1;
    drive(8'h40, 8'h40);
    chk("rm_new_rdy", rr_in_rdy, 8'h40);
    step();
    chk("rm_new_sel", rr_out_sel, 6);
    chk("rm_new_ptr", rr_dbg_ptr, 7);

    // ---- Wrap with sparse requests: ptr=7, ch0 and ch7 valid ----
    drive(8'h81, 8'h81);
    chk("wr_rdy7", rr_in_rdy, 8'h80);
    step();
    chk("wr_sel7", rr_out_sel, 7);
    chk("wr_ptr0", rr_dbg_ptr, 0);
    chk("wr_rdy0", rr_in_rdy, 8'h01);
    step();
    chk("wr_sel0", rr_out_sel, 0);
    chk("wr_ptr1", rr_dbg_ptr, 1);
    drive(8'h00, 8'h00);
    step();

    // ---- Fixed priority: ch1, ch2, ch7 valid ----
    set_ch(1, 32'hF000_0001);
    set_ch(2, 32'hF000_0002);
    set_ch(7, 32'hF000_0007);
    drive(8'h86, 8'hFF);
    chk("fp_rdy1", fp_in_rdy, 8'h02);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fp_sel1",  fp_out_sel, 1);
      chk("fp_data1", fp_out_data, 32'hF000_0001);
    end
    drive(8'h84, 8'hFF);
    chk("fp_rdy2", fp_in_rdy, 8'h04);
    step();
    chk("fp_sel2", fp_out_sel, 2);
    drive(8'h80, 8'hFF);
    chk("fp_rdy7", fp_in_rdy, 8'h80);
    step();
    chk("fp_sel7",  fp_out_sel, 7);
    chk("fp_data7", fp_out_data, 32'hF000_0007);
    drive(8'h00, 8'h00);
    step();
    chk("fp_end_vld", fp_out_vld, 0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
